// File: rtl/bb_ctrl_pkg.sv
// Shared types and K_BCH tables for the BBFRAME descrambler controller.
// Optional statistics counters in the top are enabled by BB_CTRL_STATS_EN.
package bb_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    localparam logic [3:0] RATE_1_4  = 4'd0;
    localparam logic [3:0] RATE_1_3  = 4'd1;
    localparam logic [3:0] RATE_2_5  = 4'd2;
    localparam logic [3:0] RATE_1_2  = 4'd3;
    localparam logic [3:0] RATE_3_5  = 4'd4;
    localparam logic [3:0] RATE_2_3  = 4'd5;
    localparam logic [3:0] RATE_3_4  = 4'd6;
    localparam logic [3:0] RATE_4_5  = 4'd7;
    localparam logic [3:0] RATE_5_6  = 4'd8;
    localparam logic [3:0] RATE_8_9  = 4'd9;
    localparam logic [3:0] RATE_9_10 = 4'd10;

    // Index 0 is the rightmost entry.
    localparam logic [10:0][15:0] KBCH_NORMAL = {
        16'd58192, 16'd57472, 16'd53840, 16'd51648,
        16'd48408, 16'd43040, 16'd38688, 16'd32208,
        16'd25728, 16'd21408, 16'd16008
    };

    localparam logic [9:0][15:0] KBCH_SHORT = {
        16'd14232, 16'd13152, 16'd12432, 16'd11712,
        16'd10632, 16'd9552,  16'd7032,  16'd6312,
        16'd5232,  16'd3072
    };

    function automatic logic cfg_valid(input logic       is_short,
                                       input logic [3:0] rate);
        return (rate <= RATE_9_10) && !(is_short && (rate == RATE_9_10));
    endfunction

endpackage

// File: rtl/bb_kbch_lut.sv
// Combinational frame-type/code-rate to K_BCH lookup with validity flag.
module bb_kbch_lut
    import bb_ctrl_pkg::*;
#(
    parameter int KBCH_W = 16
) (
    input  logic              cfg_short_i,
    input  logic [3:0]        cfg_rate_i,
    output logic [KBCH_W-1:0] kbch_o,
    output logic              valid_o
);

    assign valid_o = cfg_valid(cfg_short_i, cfg_rate_i);

    always_comb begin
        kbch_o = '0;
        if (valid_o) begin
            if (cfg_short_i) begin
                kbch_o = KBCH_W'(KBCH_SHORT[cfg_rate_i]);
            end else begin
                kbch_o = KBCH_W'(KBCH_NORMAL[cfg_rate_i]);
            end
        end
    end

endmodule

// File: rtl/bb_descrambler_ctrl.sv
// Frame sequencer in front of BB_Descrambler: PRBS re-init, K_BCH bit gating, SOF/EOF tags.
// Define BB_CTRL_STATS_EN to add saturating frame/error statistics outputs.
module bb_descrambler_ctrl
    import bb_ctrl_pkg::*;
#(
    parameter int DESC_LAT = 1,
    parameter int KBCH_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_bit,
    input  logic              in_sof,
    output logic              in_ready,
    input  logic              cfg_short,
    input  logic [3:0]        cfg_rate,
    output logic              desc_rst,
    output logic              desc_valid,
    output logic              desc_bit,
    output logic [KBCH_W-1:0] desc_kbch,
    input  logic              dsc_valid,
    input  logic              dsc_bit,
    output logic              out_valid,
    output logic              out_bit,
    output logic              out_sof,
    output logic              out_eof,
    output logic              err_short,
    output logic              err_cfg,
    output logic              err_orphan
`ifdef BB_CTRL_STATS_EN
    ,
    output logic [15:0]       stat_frames,
    output logic [15:0]       stat_short,
    output logic [15:0]       stat_cfg,
    output logic [15:0]       stat_orphan
`endif
);

    state_e            state_q, state_d;
    logic [KBCH_W-1:0] kbch_q, kbch_d;
    logic [KBCH_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic              hold_q, hold_d;
    logic              dvalid_q, dvalid_d;
    logic              dbit_q, dbit_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic              eshort_q, eshort_d;
    logic              ecfg_q, ecfg_d;
    logic              eorph_q, eorph_d;
    logic [DESC_LAT-1:0] sof_pipe_q, eof_pipe_q;

    logic [KBCH_W-1:0] lut_kbch;
    logic              lut_valid;
    logic              accept;

    bb_kbch_lut #(
        .KBCH_W(KBCH_W)
    ) u_lut (
        .cfg_short_i(cfg_short),
        .cfg_rate_i (cfg_rate),
        .kbch_o     (lut_kbch),
        .valid_o    (lut_valid)
    );

    assign in_ready = (state_q != ST_INIT);
    assign accept   = in_valid & in_ready;
    assign cnt_inc  = cnt_q + KBCH_W'(1);

    always_comb begin
        state_d  = state_q;
        kbch_d   = kbch_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        dvalid_d = 1'b0;
        dbit_d   = dbit_q;
        first_d  = 1'b0;
        last_d   = 1'b0;
        eshort_d = 1'b0;
        ecfg_d   = 1'b0;
        eorph_d  = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                dvalid_d = 1'b1;
                dbit_d   = hold_q;
                cnt_d    = KBCH_W'(1);
                first_d  = 1'b1;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                if (accept && !in_sof) begin
                    dvalid_d = 1'b1;
                    dbit_d   = in_bit;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == kbch_q) begin
                        last_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                eorph_d = accept & ~in_sof;
            end
            default: begin
            end
        endcase

        // A SOF restarts from any accepting state; a running frame is aborted.
        if (accept && in_sof) begin
            eshort_d = (state_q == ST_RUN);
            cnt_d    = '0;
            if (lut_valid) begin
                kbch_d  = lut_kbch;
                hold_d  = in_bit;
                state_d = ST_INIT;
            end else begin
                ecfg_d  = 1'b1;
                state_d = ST_DROP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            kbch_q   <= '0;
            cnt_q    <= '0;
            hold_q   <= 1'b0;
            dvalid_q <= 1'b0;
            dbit_q   <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            eshort_q <= 1'b0;
            ecfg_q   <= 1'b0;
            eorph_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            kbch_q   <= kbch_d;
            cnt_q    <= cnt_d;
            hold_q   <= hold_d;
            dvalid_q <= dvalid_d;
            dbit_q   <= dbit_d;
            first_q  <= first_d;
            last_q   <= last_d;
            eshort_q <= eshort_d;
            ecfg_q   <= ecfg_d;
            eorph_q  <= eorph_d;
        end
    end

    // Tags travel alongside the descrambler's own latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sof_pipe_q <= '0;
            eof_pipe_q <= '0;
        end else begin
            sof_pipe_q[0] <= first_q;
            eof_pipe_q[0] <= last_q;
            for (int i = 1; i < DESC_LAT; i++) begin
                sof_pipe_q[i] <= sof_pipe_q[i-1];
                eof_pipe_q[i] <= eof_pipe_q[i-1];
            end
        end
    end

    assign desc_rst   = rst | (state_q == ST_INIT);
    assign desc_valid = dvalid_q;
    assign desc_bit   = dbit_q;
    assign desc_kbch  = kbch_q;
    assign out_valid  = dsc_valid;
    assign out_bit    = dsc_bit;
    assign out_sof    = sof_pipe_q[DESC_LAT-1] & dsc_valid;
    assign out_eof    = eof_pipe_q[DESC_LAT-1] & dsc_valid;
    assign err_short  = eshort_q;
    assign err_cfg    = ecfg_q;
    assign err_orphan = eorph_q;

`ifdef BB_CTRL_STATS_EN
    logic [15:0] st_frames_q, st_short_q, st_cfg_q, st_orphan_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_frames_q <= '0;
            st_short_q  <= '0;
            st_cfg_q    <= '0;
            st_orphan_q <= '0;
        end else begin
            if (out_eof && st_frames_q != 16'hFFFF) st_frames_q <= st_frames_q + 16'd1;
            if (eshort_q && st_short_q != 16'hFFFF) st_short_q <= st_short_q + 16'd1;
            if (ecfg_q && st_cfg_q != 16'hFFFF) st_cfg_q <= st_cfg_q + 16'd1;
            if (eorph_q && st_orphan_q != 16'hFFFF) st_orphan_q <= st_orphan_q + 16'd1;
        end
    end

    assign stat_frames = st_frames_q;
    assign stat_short  = st_short_q;
    assign stat_cfg    = st_cfg_q;
    assign stat_orphan = st_orphan_q;
`endif

endmodule

// File: tb/tb_bb_descrambler_ctrl.sv
// Randomized scoreboard bench for bb_descrambler_ctrl with a stand-in PRBS descrambler.
// Builds with or without BB_CTRL_STATS_EN.
module tb_bb_descrambler_ctrl;

    localparam int KBCH_W = 16;
    localparam logic [14:0] PRBS_INIT = 15'b100101010000000;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DROP = 2;

    typedef struct packed {
        logic b;
        logic sof;
        logic eof;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_bit, in_sof, in_ready;
    logic cfg_short;
    logic [3:0] cfg_rate;
    logic desc_rst, desc_valid, desc_bit;
    logic [KBCH_W-1:0] desc_kbch;
    logic dsc_valid, dsc_bit;
    logic out_valid, out_bit, out_sof, out_eof;
    logic err_short, err_cfg, err_orphan;
`ifdef BB_CTRL_STATS_EN
    logic [15:0] stat_frames, stat_short, stat_cfg, stat_orphan;
`endif

    always #5 clk = ~clk;

    bb_descrambler_ctrl #(
        .DESC_LAT(1),
        .KBCH_W  (KBCH_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .cfg_short  (cfg_short),
        .cfg_rate   (cfg_rate),
        .desc_rst   (desc_rst),
        .desc_valid (desc_valid),
        .desc_bit   (desc_bit),
        .desc_kbch  (desc_kbch),
        .dsc_valid  (dsc_valid),
        .dsc_bit    (dsc_bit),
        .out_valid  (out_valid),
        .out_bit    (out_bit),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .err_short  (err_short),
        .err_cfg    (err_cfg),
        .err_orphan (err_orphan)
`ifdef BB_CTRL_STATS_EN
        ,
        .stat_frames(stat_frames),
        .stat_short (stat_short),
        .stat_cfg   (stat_cfg),
        .stat_orphan(stat_orphan)
`endif
    );

    // Stand-in descrambler: one cycle latency, PRBS reloaded while desc_rst is high.
    logic [14:0] lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr      <= PRBS_INIT;
            dsc_valid <= 1'b0;
            dsc_bit   <= 1'b0;
        end else begin
            dsc_valid <= desc_valid;
            if (desc_valid) dsc_bit <= desc_bit ^ lfsr[13] ^ lfsr[14];
            if (desc_rst) lfsr <= PRBS_INIT;
            else if (desc_valid) lfsr <= {lfsr[13:0], lfsr[13] ^ lfsr[14]};
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    exp_t sq[$];
    int   kq[$];
    logic prbs [0:16383];
    int kn [0:10] = '{16008, 21408, 25728, 32208, 38688, 43040,
                      48408, 51648, 53840, 57472, 58192};
    int ks [0:9]  = '{3072, 5232, 6312, 7032, 9552, 10632,
                      11712, 12432, 13152, 14232};

    int mode = M_IDLE;
    int idx = 0;
    int cur_k = 0;
    int exp_short = 0, exp_cfg = 0, exp_orph = 0, exp_init = 0, exp_eof = 0;
    int seen_short = 0, seen_cfg = 0, seen_orph = 0, seen_init = 0, seen_eof = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int kbch_ref(input logic s, input logic [3:0] r);
        if (r > 4'd10) return 0;
        if (s) return (r == 4'd10) ? 0 : ks[r];
        return kn[r];
    endfunction

    task automatic push_bit(input logic b);
        exp_t e;
        e.b   = b ^ prbs[idx];
        e.sof = (idx == 0);
        e.eof = (idx == cur_k - 1);
        sq.push_back(e);
        kq.push_back(cur_k);
        idx++;
        if (idx == cur_k) begin
            mode = M_IDLE;
            exp_eof++;
        end
    endtask

    task automatic model(input logic b, input logic s, input logic cs, input logic [3:0] cr);
        int k;
        if (s) begin
            if (mode == M_RUN) exp_short++;
            k = kbch_ref(cs, cr);
            if (k == 0) begin
                exp_cfg++;
                mode = M_DROP;
            end else begin
                exp_init++;
                cur_k = k;
                idx = 0;
                mode = M_RUN;
                push_bit(b);
            end
        end else if (mode == M_RUN) begin
            push_bit(b);
        end else if (mode == M_IDLE) begin
            exp_orph++;
        end
    endtask

    // Present one beat and hold it until accepted.
    task automatic beat(input logic b, input logic s, input logic cs, input logic [3:0] cr);
        int w;
        in_valid  = 1'b1;
        in_bit    = b;
        in_sof    = s;
        cfg_short = cs;
        cfg_rate  = cr;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 8) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: in_ready=0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        model(b, s, cs, cr);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_err_short"}, seen_short, exp_short);
        chk({tag, "_err_cfg"}, seen_cfg, exp_cfg);
        chk({tag, "_err_orphan"}, seen_orph, exp_orph);
        chk({tag, "_init_pulses"}, seen_init, exp_init);
        chk({tag, "_eof_count"}, seen_eof, exp_eof);
`ifdef BB_CTRL_STATS_EN
        chk({tag, "_stat_frames"}, int'(stat_frames), exp_eof);
        chk({tag, "_stat_short"}, int'(stat_short), exp_short);
        chk({tag, "_stat_cfg"}, int'(stat_cfg), exp_cfg);
        chk({tag, "_stat_orphan"}, int'(stat_orphan), exp_orph);
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_desc_valid"}, int'(desc_valid), 0);
        chk({tag, "_desc_bit"}, int'(desc_bit), 0);
        chk({tag, "_desc_kbch"}, int'(desc_kbch), 0);
        chk({tag, "_out_sof_eof"}, int'({out_valid, out_sof, out_eof}), 0);
        chk({tag, "_errs"}, int'({err_short, err_cfg, err_orphan}), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sq.delete();
        kq.delete();
        mode = M_IDLE;
        @(negedge clk);
        check_idle_outputs("midrst");
        chk("midrst_desc_rst", int'(desc_rst), 1);
`ifdef BB_CTRL_STATS_EN
        chk("midrst_stat_frames", int'(stat_frames), 0);
`endif
        exp_short = 0; exp_cfg = 0; exp_orph = 0; exp_init = 0; exp_eof = 0;
        seen_short = 0; seen_cfg = 0; seen_orph = 0; seen_init = 0; seen_eof = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycle();
    endtask

    task automatic frame(input logic cs, input logic [3:0] cr, input int nbits,
                         input int gap_pct, input int rst_at);
        for (int i = 0; i < nbits; i++) begin
            while (int'($urandom_range(99)) < gap_pct) idle_cycle();
            if (i == 0) beat(1'($urandom_range(1)), 1'b1, cs, cr);
            else beat(1'($urandom_range(1)), 1'b0, 1'($urandom_range(1)),
                      4'($urandom_range(15)));
            if (rst_at != 0 && i == rst_at) begin
                do_reset();
                return;
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents data.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (dsc_valid) begin
                if (sq.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    e = sq.pop_front();
                    chk("out_data", int'({out_valid, out_bit, out_sof, out_eof}),
                        int'({1'b1, e.b, e.sof, e.eof}));
                end
            end else begin
                if (out_valid | out_sof | out_eof) chk("idle_out", int'({out_valid, out_sof, out_eof}), 0);
            end
            if (desc_valid) begin
                if (kq.size() == 0) chk("unexpected_desc_valid", 1, 0);
                else chk("desc_kbch", int'(desc_kbch), kq.pop_front());
            end
            if (err_short) seen_short++;
            if (err_cfg) seen_cfg++;
            if (err_orphan) seen_orph++;
            if (desc_rst) seen_init++;
            if (out_eof) seen_eof++;
        end
    end

    initial begin
        logic [14:0] r;
        r = PRBS_INIT;
        for (int i = 0; i < 16384; i++) begin
            prbs[i] = r[13] ^ r[14];
            r = {r[13:0], prbs[i]};
        end
        rst = 1'b1;
        in_valid = 1'b0; in_bit = 1'b0; in_sof = 1'b0;
        cfg_short = 1'b0; cfg_rate = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_desc_rst", int'(desc_rst), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_desc_rst", int'(desc_rst), 0);
        check_idle_outputs("post_reset");
        idle_cycle();

        repeat (5) beat(1'($urandom_range(1)), 1'b0, 1'b0, 4'd3);
        frame(1'b1, 4'd3, 7032, 0, 0);
        frame(1'b0, 4'd0, 16008, 0, 0);
        frame(1'b1, 4'd0, 3072, 0, 0);
        frame(1'b1, 4'd0, 100, 0, 0);
        frame(1'b1, 4'd0, 3072, 0, 0);
        beat(1'b1, 1'b1, 1'b1, 4'd10);
        repeat (50) beat(1'($urandom_range(1)), 1'b0, 1'b0, 4'd0);
        beat(1'b0, 1'b1, 1'b0, 4'(11 + $urandom_range(4)));
        repeat (20) beat(1'($urandom_range(1)), 1'b0, 1'b0, 4'd0);
        frame(1'b1, 4'd1, 5232, 10, 0);
        repeat (10) idle_cycle();
        check_counts("pre_rst");
        frame(1'b1, 4'd0, 3072, 30, 1500);
        frame(1'b1, 4'd0, 3072, 30, 0);
        frame(1'b0, 4'd10, 200, 20, 0);
        frame(1'b1, 4'd9, 14232, 0, 0);
        repeat (3) beat(1'($urandom_range(1)), 1'b0, 1'b1, 4'd2);
        repeat (10) idle_cycle();
        chk("scoreboard_drained", sq.size(), 0);
        chk("kbch_queue_drained", kq.size(), 0);
        check_counts("final");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bb_descrambler_ctrl.md
Name: bb_descrambler_ctrl

Overview:
- Frame-level sequencer in front of BB_Descrambler.
- Accepts a serial BBFRAME bit stream with start-of-frame marks and decodes the frame-type/code-rate configuration into K_BCH.
- Re-initialises the descrambler PRBS at every frame start, forwards exactly K_BCH bits per frame, and tags descrambled output with SOF/EOF.
- Detects short, orphan and misconfigured frames.

Parameters:
- DESC_LAT, 1, descrambler input-to-output latency in cycles; SOF/EOF tag pipeline depth.
- KBCH_W, 16, width of the K_BCH bus and bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  upstream bit valid.
- in_bit  in  1  upstream data bit.
- in_sof  in  1  first bit of a BBFRAME; qualified by in_valid.
- in_ready  out  1  controller accepts a beat when in_valid & in_ready.
- cfg_short  in  1  0 = normal FECFRAME, 1 = short; sampled on the SOF beat.
- cfg_rate  in  4  code-rate index 0..10 (1/4,1/3,2/5,1/2,3/5,2/3,3/4,4/5,5/6,8/9,9/10); sampled on the SOF beat.
- desc_rst  out  1  descrambler reset = rst OR one-cycle init pulse.
- desc_valid  out  1  to descrambler valid_in.
- desc_bit  out  1  to descrambler bit_stream_in.
- desc_kbch  out  KBCH_W  to descrambler K_BCH; held for the whole frame.
- dsc_valid  in  1  from descrambler valid_out.
- dsc_bit  in  1  from descrambler bit_stream_out.
- out_valid  out  1  equals dsc_valid.
- out_bit  out  1  equals dsc_bit.
- out_sof  out  1  first descrambled bit of a frame.
- out_eof  out  1  last descrambled bit of a frame.
- err_short  out  1  one-cycle pulse: new SOF arrived before K_BCH bits.
- err_cfg  out  1  one-cycle pulse: invalid cfg on the SOF beat.
- err_orphan  out  1  one-cycle pulse: non-SOF beat in IDLE.

Behaviour:
- Reset: state IDLE; in_ready=1; desc_valid=0, desc_bit=0, desc_kbch=0; all out_* and err_* = 0; counter=0.
- K_BCH lookup, normal: 16008, 21408, 25728, 32208, 38688, 43040, 48408, 51648, 53840, 57472, 58192.
- K_BCH lookup, short: 3072, 5232, 6312, 7032, 9552, 10632, 11712, 12432, 13152, 14232.
- Invalid cfg: cfg_rate>10, or cfg_short=1 with cfg_rate=10.
- IDLE: in_ready=1.
  - SOF beat with valid cfg: latch K_BCH into desc_kbch and in_bit into the hold register; go to INIT.
  - SOF beat with invalid cfg: err_cfg pulse; go to DROP.
  - Non-SOF beat: err_orphan pulse; bit discarded.
- INIT (exactly 1 cycle): in_ready=0; desc_rst=1; desc_valid=0. Next cycle: desc_valid=1, desc_bit=hold, counter=1, first-tag set; go to RUN.
- RUN: in_ready=1. Each accepted beat registers to desc_bit/desc_valid the next cycle (1-cycle latency); counter increments on every presented bit.
  - The bit presented when counter reaches K_BCH carries the last-tag; state returns to IDLE the same cycle.
  - in_valid low: desc_valid=0 next cycle; counter holds.
  - SOF beat before K_BCH bits presented: err_short pulse; abort frame (its last-tag is never issued); restart as in IDLE with the new cfg (INIT or DROP).
- DROP: in_ready=1; non-SOF beats discarded silently; a SOF beat is handled as in IDLE.
- Tags: first/last tags are delayed DESC_LAT cycles and ANDed with dsc_valid to form out_sof/out_eof. K_BCH=1 is impossible, so out_sof and out_eof never coincide.
- desc_kbch changes only in INIT, so the descrambler sees a stable K_BCH for the whole frame.
- The last bit of frame N may be accepted in the same cycle as the check for frame N+1's SOF. The last-bit beat returns to IDLE; the next beat is evaluated in IDLE.
- rst asserted mid-frame: everything returns to reset values immediately; no EOF is emitted.

Optional Feature:
- Macro: BB_CTRL_STATS_EN.
- Defined: extra outputs stat_frames, stat_short, stat_cfg, stat_orphan, each 16 bits, saturating at 16'hFFFF, cleared by rst.
  - stat_frames counts frames that reach out_eof.
  - The other three count their corresponding err_* pulses.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package bb_ctrl_pkg holds:
  - state enum {IDLE, INIT, RUN, DROP};
  - 4-bit code-rate index constants;
  - normal and short K_BCH constant tables;
  - the cfg-valid function.
- One sub-module: bb_kbch_lut (combinational cfg_short/cfg_rate to K_BCH plus valid flag), reusable by the BCH decoder controller.

Test Plan:
- Short frame, rate 3 (K_BCH=7032), continuous valid → one desc_rst pulse; 7032 desc_valid beats; out_sof on the first and out_eof on the 7032nd output; output equals MATLAB reference bits.
- Two back-to-back normal frames, rate 0 (16008) → second INIT follows the first EOF; desc_kbch stable; bit counts 16008 each; no errors.
- SOF after 100 bits of a 3072-bit frame → err_short=1 for one cycle; no out_eof for the first frame; the new frame completes with 3072 bits.
- cfg_short=1, rate 10 → err_cfg pulse; state DROP; 50 following bits give desc_valid=0; the next valid SOF is processed normally.
- Non-SOF beats in IDLE after reset → err_orphan pulses; desc_valid stays 0.
- 30% random in_valid gaps within a 3072-bit frame, plus rst asserted at bit 1500 → counts preserved across gaps; reset clears state and no out_eof is emitted. With BB_CTRL_STATS_EN, stat_frames=0 after the reset.
